alu_mul_seq: RTL and testbench

- Multi-cycle signed 16x16 saturating multiply sequencer. It borrows the EX-stage ALU, using only its ADD and SUB functions, and runs a Horner shift-and-add loop.
- While busy, it asserts alu_own so the EX operand mux selects its operands, and the pipeline stalls on busy.
- The result is the signed product clamped to 16 bits, consistent with the ALU's saturating arithmetic.

---
 rtl/alu_mul_seq_pkg.sv | 43 ++++
 rtl/mul_lod16.sv | 18 +
 rtl/alu_mul_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_mul_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared types and constants for the sequential saturating multiplier.
// ALU function codes must match the EX-stage ALU encoding.
package alu_mul_seq_pkg;

  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_SUB = 5'h01;

  localparam int          MUL_ITERS = 15;
  localparam logic [15:0] SAT_POS   = 16'h7FFF;
  localparam logic [15:0] SAT_NEG   = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_DBL,
    S_ACC,
    S_NEG,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [15:0] src1;
    logic [15:0] src0;
    logic [4:0]  func;
  } alu_req_t;

  // Magnitude request: 0 - v for negatives, v + 0 otherwise.
  function automatic alu_req_t abs_req(input logic [15:0] v);
    alu_req_t r;
    if (v[15]) begin
      r.src1 = 16'h0000;
      r.src0 = v;
      r.func = ALU_SUB;
    end else begin
      r.src1 = v;
      r.src0 = 16'h0000;
      r.func = ALU_ADD;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_lod16.sv
// Combinational leading-one detector over a 15-bit magnitude.
// idx_o is the highest set bit position; zero_o flags an all-zero input.
module mul_lod16 (
  input  logic [14:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        zero_o
);

  always_comb begin
    idx_o = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

  assign zero_o = (vec_i == 15'd0);

endmodule

// File: rtl/alu_mul_seq.sv
// Signed 16x16 saturating multiply run as a Horner shift-and-add loop on the borrowed EX ALU.
// Define MUL_EARLY_EXIT_EN to start the loop at the multiplier's leading one.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          ov,
  output logic          alu_own,
  output logic [DW-1:0] alu_src0,
  output logic [DW-1:0] alu_src1,
  output logic [4:0]    alu_func,
  output logic [3:0]    alu_shamt,
  input  logic [DW-1:0] alu_dst,
  input  logic          alu_ov
);

  state_e         state_q;
  logic [DW-1:0]  op_b_q;
  logic [DW-1:0]  mag_a_q;
  logic [DW-1:0]  mag_b_q;
  logic [DW-1:0]  acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic           sign_q;
  logic           sticky_q;
  logic           sticky_d;
  logic           busy_q;
  logic           done_q;
  logic [DW-1:0]  result_q;
  logic           ov_q;
  logic [DW-1:0]  src0_q;
  logic [DW-1:0]  src1_q;
  logic [4:0]     func_q;
  logic [CNT_W-1:0] cnt_load;
  logic           mag_b_zero;
  alu_req_t       req_a;
  alu_req_t       req_b;

`ifdef MUL_EARLY_EXIT_EN
  mul_lod16 u_lod (
    .vec_i  (alu_dst[14:0]),
    .idx_o  (cnt_load),
    .zero_o (mag_b_zero)
  );
`else
  assign cnt_load   = CNT_W'(MUL_ITERS - 1);
  assign mag_b_zero = 1'b0;
`endif

  assign req_a    = abs_req(op_a);
  assign req_b    = abs_req(op_b_q);
  assign sticky_d = sticky_q | alu_ov;

  // ALU operands are registered one state ahead, so each transition loads the next op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_b_q   <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
      src0_q   <= '0;
      src1_q   <= '0;
      func_q   <= ALU_ADD;
    end else begin
      done_q <= 1'b0;
      if (state_q inside {S_ABS_A, S_ABS_B, S_DBL, S_ACC}) sticky_q <= sticky_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_b_q   <= op_b;
            sign_q   <= op_a[DW-1] ^ op_b[DW-1];
            acc_q    <= '0;
            sticky_q <= 1'b0;
            src1_q   <= req_a.src1;
            src0_q   <= req_a.src0;
            func_q   <= req_a.func;
            busy_q   <= 1'b1;
            state_q  <= S_ABS_A;
          end
        end
        S_ABS_A: begin
          mag_a_q <= alu_dst;
          src1_q  <= req_b.src1;
          src0_q  <= req_b.src0;
          func_q  <= req_b.func;
          state_q <= S_ABS_B;
        end
        S_ABS_B: begin
          mag_b_q <= alu_dst;
          cnt_q   <= cnt_load;
          src1_q  <= acc_q;
          src0_q  <= acc_q;
          if (mag_b_zero) begin
            func_q  <= ALU_SUB;
            state_q <= S_NEG;
          end else begin
            func_q  <= ALU_ADD;
            state_q <= S_DBL;
          end
        end
        S_DBL: begin
          acc_q   <= alu_dst;
          src1_q  <= alu_dst;
          src0_q  <= mag_b_q[cnt_q] ? mag_a_q : '0;
          func_q  <= ALU_ADD;
          state_q <= S_ACC;
        end
        S_ACC: begin
          acc_q <= alu_dst;
          if (cnt_q == '0) begin
            src1_q  <= '0;
            src0_q  <= alu_dst;
            func_q  <= ALU_SUB;
            state_q <= S_NEG;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            src1_q  <= alu_dst;
            src0_q  <= alu_dst;
            func_q  <= ALU_ADD;
            state_q <= S_DBL;
          end
        end
        S_NEG: begin
          // Loop saturation is absorbing, so sticky_q alone decides clamping.
          if (acc_q == '0) result_q <= '0;
          else if (sign_q) result_q <= sticky_q ? SAT_NEG : alu_dst;
          else result_q <= sticky_q ? SAT_POS : acc_q;
          ov_q    <= sticky_q & (acc_q != '0);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          src1_q  <= '0;
          src0_q  <= '0;
          func_q  <= ALU_ADD;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign alu_own   = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign ov        = ov_q;
  assign alu_src0  = src0_q;
  assign alu_src1  = src1_q;
  assign alu_func  = func_q;
  assign alu_shamt = 4'd0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: saturating ALU model, directed vectors, random vectors vs. arithmetic model.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ov;
  logic        alu_own;
  logic [15:0] alu_src0;
  logic [15:0] alu_src1;
  logic [4:0]  alu_func;
  logic [3:0]  alu_shamt;
  logic [15:0] alu_dst;
  logic        alu_ov;

  int checks = 0;
  int errors = 0;

  alu_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ov        (ov),
    .alu_own   (alu_own),
    .alu_src0  (alu_src0),
    .alu_src1  (alu_src1),
    .alu_func  (alu_func),
    .alu_shamt (alu_shamt),
    .alu_dst   (alu_dst),
    .alu_ov    (alu_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Saturating EX ALU: ADD = src1+src0, SUB = src1-src0.
  int alu_sum;
  always_comb begin
    if (alu_func == ALU_SUB) alu_sum = int'($signed(alu_src1)) - int'($signed(alu_src0));
    else alu_sum = int'($signed(alu_src1)) + int'($signed(alu_src0));
    alu_ov  = 1'b0;
    alu_dst = alu_sum[15:0];
    if (alu_sum > 32767) begin
      alu_dst = 16'h7FFF;
      alu_ov  = 1'b1;
    end else if (alu_sum < -32768) begin
      alu_dst = 16'h8000;
      alu_ov  = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  // Product of magnitudes (0x8000 counts as 0x7FFF and forces ov), then signed clamp.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic o);
    int  p;
    bit  sat;
    bit  neg;
    sat = (a == 16'h8000) || (b == 16'h8000);
    p   = mag_of(a) * mag_of(b);
    neg = a[15] ^ b[15];
    if (p == 0) begin
      r = 16'h0000;
      o = 1'b0;
    end else begin
      if (p > 32767) sat = 1'b1;
      if (sat) r = neg ? 16'h8000 : 16'h7FFF;
      else r = neg ? 16'(-p) : 16'(p);
      o = sat;
    end
  endfunction

  function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int m;
    int msb;
    m = mag_of(b);
    if (m == 0) return 4;
    msb = 0;
    for (int i = 0; i < 15; i++) if (((m >> i) & 1) != 0) msb = i;
    return 4 + 2 * (msb + 1);
`else
    return 34;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eo, input int pulse);
    int cyc;
    int busy_bad;
    int aux_bad;
    bit seen;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    cyc = 1;
    seen = 1'b0;
    busy_bad = 0;
    aux_bad = 0;
    while (!seen && cyc <= 80) begin
      start = (cyc == pulse);
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
      if (alu_own !== busy || alu_shamt !== 4'd0 ||
          !(alu_func == ALU_ADD || alu_func == ALU_SUB)) aux_bad++;
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat(b)));
    chk({tag, " busy_run"}, 32'(busy_bad), 32'd0);
    chk({tag, " alu_ctl"}, 32'(aux_bad), 32'd0);
    chk({tag, " result"}, {16'd0, result}, {16'd0, er});
    chk({tag, " ov"}, {31'd0, ov}, {31'd0, eo});
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle_after"}, {30'd0, busy, alu_own}, 32'd0);
    chk({tag, " result_held"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] er;
    logic        eo;
    int          dcnt;
    int          bcnt;
    int          mode;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst own", {31'd0, alu_own}, 32'd0);
    chk("rst ov", {31'd0, ov}, 32'd0);
    chk("rst result", {16'd0, result}, 32'd0);
    chk("rst src0", {16'd0, alu_src0}, 32'd0);
    chk("rst src1", {16'd0, alu_src1}, 32'd0);
    chk("rst func", {27'd0, alu_func}, {27'd0, ALU_ADD});
    rst_n = 1'b1;

    run_op("3x5", 16'h0003, 16'h0005, 16'h000F, 1'b0, 0);
    run_op("start_ignored", 16'h0003, 16'h0005, 16'h000F, 1'b0, 5);
    run_op("sat_pos", 16'h0100, 16'h0100, 16'h7FFF, 1'b1, 0);
    run_op("sat_neg", 16'hFF00, 16'h0100, 16'h8000, 1'b1, 0);
    run_op("m7x6", 16'hFFF9, 16'h0006, 16'hFFD6, 1'b0, 0);
    run_op("m7xm6", 16'hFFF9, 16'hFFFA, 16'h002A, 1'b0, 0);
    run_op("min_x1", 16'h8000, 16'h0001, 16'h8000, 1'b1, 0);
    run_op("min_x0", 16'h8000, 16'h0000, 16'h0000, 1'b0, 0);
`ifdef MUL_EARLY_EXIT_EN
    run_op("ee_5x1", 16'h0005, 16'h0001, 16'h0005, 1'b0, 0);
    run_op("ee_7x0", 16'h0007, 16'h0000, 16'h0000, 1'b0, 0);
`endif
    run_op("min_xm1", 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 0);

    // Abort an operation with reset in its cycle 10.
    @(negedge clk);
    op_a  = 16'h1234;
    op_b  = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort own", {31'd0, alu_own}, 32'd0);
    chk("abort result", {16'd0, result}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
      if (busy !== 1'b0) bcnt++;
    end
    chk("abort no_done", 32'(dcnt), 32'd0);
    chk("abort stays_idle", 32'(bcnt), 32'd0);

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        ra = 16'($urandom_range(0, 255));
        rb = 16'($urandom_range(0, 255));
      end else if (mode == 1) begin
        ra = 16'($urandom);
        rb = 16'($urandom_range(0, 3));
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      model(ra, rb, er, eo);
      run_op($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, er, eo, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
